apb_fmac_seq: RTL and testbench
===============================

// Module: apb_fmac_seq
// PURPOSE
//  APB master sequencer directly upstream of apb_fmac. Accepts operand triplets
//  (A,B,C) on a valid/ready stream and performs the full apb_fmac sequence:
//  write A/B/C, write CTL to start, poll STATUS until idle, read RESULT.
//  Returns RESULT on a valid/ready output stream.
//  One operation in flight; no APB bus sharing.
// PARAMETERS
//  POLL_GAP     2     idle cycles inserted before each STATUS poll (0..255)
//  POLL_LIMIT   64    max STATUS polls before abort with error (1..65535)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, asynchronous, active-high
//  in_valid     in   1   operand triplet valid
//  in_ready     out  1   sequencer can accept triplet
//  in_a         in   32  operand A (fp32)
//  in_b         in   32  operand B (fp32)
//  in_c         in   32  operand C (fp32)
//  out_valid    out  1   result valid
//  out_ready    in   1   consumer accepts result
//  out_data     out  32  RESULT register value (0 on error)
//  out_err      out  1   poll limit exceeded, qualifies out_data
//  apb_paddr    out  5   APB address
//  apb_psel     out  1   APB select
//  apb_penable  out  1   APB enable
//  apb_pwrite   out  1   APB direction, 1=write
//  apb_pwdata   out  32  APB write data
//  apb_prdata   in   32  APB read data
//  apb_pready   in   1   APB ready, sampled in access phase only
// BEHAVIOUR
//  Register map driven: A=0x00, B=0x04, C=0x08, RESULT=0x0C, CTL/STATUS=0x14.
//   Write to 0x14 starts the operation. Read of 0x14 returns bit0=busy.
//  Reset values:
//   in_ready=1. All other outputs 0 (out_*, apb_*).
//   Internal triplet and poll counter also clear.
//  Input handshake:
//   Triplet is latched on in_valid & in_ready.
//   in_ready=1 only in IDLE.
//  States:
//   IDLE -> WR_A -> WR_B -> WR_C -> WR_CTL -> GAP -> POLL -> RD_RES -> OUT -> IDLE.
//   POLL busy=1 -> GAP if polls<POLL_LIMIT, else -> OUT with out_err=1.
//   POLL busy=0 -> RD_RES.
//   With POLL_GAP=0, GAP lasts 0 cycles, i.e. it is bypassed.
//  APB transfer per state:
//   Setup cycle: psel=1, penable=0; paddr/pwrite/pwdata valid.
//   Access cycle(s): psel=1, penable=1, held until pready=1.
//   Next transfer's setup is the cycle after completion.
//   psel never drops between back-to-back transfers except in GAP.
//   paddr/pwrite/pwdata are stable from setup until completion.
//   CTL write data = 0.
//  prdata is captured on the access cycle with pready=1.
//   STATUS bit0 only is examined; RESULT is captured as 32 bits.
//  Latency with pready tied 1, POLL_GAP=G, one poll with busy=0, handshake at edge E:
//   - first setup in cycle E+1; writes occupy 8 cycles;
//   - poll setup at E+9+G; RESULT read at E+11+G;
//   - out_valid rises at edge E+13+G.
//  Output handshake:
//   out_valid is held with out_data/out_err stable until out_ready=1.
//   Return to IDLE occurs on that edge; in_ready=1 in the next cycle.
//  Poll counter:
//   16-bit, cleared on leaving IDLE, incremented per completed poll.
//   Compared with POLL_LIMIT after increment.
//  Reset mid-operation: bus is released asynchronously (psel=penable=0), no
//   completion is reported, and the triplet is discarded.
//  pready high outside an access phase is ignored.
// TESTING
//  1. Reset: rst=1 -> in_ready=1, psel=0, out_valid=0. Hold in_valid=1 during rst -> no capture.
//  2. Single op, slave model pready=1, busy for 3 polls:
//     in A=0x401a3237, B=0x3eae76d1, C=0x3ee9c749, RESULT=0x3fe1_0000
//     -> writes 0x00,0x04,0x08,0x14 with exact data; 4 reads of 0x14; read of 0x0C;
//     -> out_data=0x3fe10000, out_err=0.
//  3. Wait states: slave inserts 2 pready=0 cycles per access
//     -> addr/data stable throughout and no duplicated transfer.
//  4. Timeout: POLL_LIMIT=4, STATUS stuck busy
//     -> exactly 4 polls, then out_valid=1, out_err=1, out_data=0; no 0x0C read.
//  5. Backpressure: out_ready=0 for 10 cycles
//     -> out_valid/out_data held; in_ready=0 until accept; next triplet follows accept.
//  6. Reset asserted during WR_B access -> psel/penable drop immediately;
//     after release only IDLE with in_ready=1 and no out_valid.

Source files
------------

// File: rtl/apb_fmac_seq.sv
// APB master sequencer for apb_fmac: writes A/B/C, starts the unit, polls STATUS
// until idle and returns RESULT (or an error after POLL_LIMIT busy polls).
module apb_fmac_seq #(
    parameter int POLL_GAP   = 2,
    parameter int POLL_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic [4:0]  apb_paddr,
    output logic        apb_psel,
    output logic        apb_penable,
    output logic        apb_pwrite,
    output logic [31:0] apb_pwdata,
    input  logic [31:0] apb_prdata,
    input  logic        apb_pready
);
    typedef enum logic [3:0] {
        IDLE, WR_A, WR_B, WR_C, WR_CTL, GAP, POLL, RD_RES, OUT
    } state_t;

    localparam logic [4:0]  ADDR_A   = 5'h00;
    localparam logic [4:0]  ADDR_B   = 5'h04;
    localparam logic [4:0]  ADDR_C   = 5'h08;
    localparam logic [4:0]  ADDR_RES = 5'h0C;
    localparam logic [4:0]  ADDR_CTL = 5'h14;
    localparam logic [7:0]  GAP_LAST = 8'(POLL_GAP - 1);
    localparam logic [15:0] LIMIT    = 16'(POLL_LIMIT);

    state_t      state_r, state_s;
    logic        psel_r, psel_s, penable_r, penable_s, pwrite_r, pwrite_s;
    logic [4:0]  paddr_r, paddr_s;
    logic [31:0] pwdata_r, pwdata_s;
    logic [31:0] a_r, a_s, b_r, b_s, c_r, c_s;
    logic [7:0]  gap_cnt_r, gap_cnt_s;
    logic [15:0] poll_cnt_r, poll_cnt_s, poll_inc_s;
    logic        in_ready_r, in_ready_s, out_valid_r, out_valid_s, out_err_r, out_err_s;
    logic [31:0] out_data_r, out_data_s;

    // Next-state, bus phase and output computation
    always_comb begin
        state_s     = state_r;
        psel_s      = psel_r;
        penable_s   = penable_r;
        pwrite_s    = pwrite_r;
        paddr_s     = paddr_r;
        pwdata_s    = pwdata_r;
        a_s         = a_r;
        b_s         = b_r;
        c_s         = c_r;
        gap_cnt_s   = gap_cnt_r;
        poll_cnt_s  = poll_cnt_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;
        out_err_s   = out_err_r;
        out_data_s  = out_data_r;
        poll_inc_s  = poll_cnt_r + 16'd1;

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    a_s        = in_a;
                    b_s        = in_b;
                    c_s        = in_c;
                    poll_cnt_s = 16'd0;
                    in_ready_s = 1'b0;
                    paddr_s    = ADDR_A;
                    pwrite_s   = 1'b1;
                    pwdata_s   = in_a;
                    state_s    = WR_A;
                end else begin
                    in_ready_s = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
                    paddr_s   = ADDR_CTL;
                    pwrite_s  = 1'b0;
                    pwdata_s  = 32'h0;
                    state_s   = POLL;
                end else begin
                    gap_cnt_s = gap_cnt_r + 8'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    out_err_s   = 1'b0;
                    out_data_s  = 32'h0;
                    in_ready_s  = 1'b1;
                    state_s     = IDLE;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            WR_A, WR_B, WR_C, WR_CTL, POLL, RD_RES: begin
                // Transfer states share one setup/access engine; the first entry from IDLE launches setup
                if (!psel_r) begin
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
                end else if (!penable_r) begin
                    penable_s = 1'b1;
                end else if (apb_pready) begin
                    penable_s = 1'b0;
                    case (state_r)
                        WR_A: begin
                            paddr_s  = ADDR_B;
                            pwdata_s = b_r;
                            state_s  = WR_B;
                        end
                        WR_B: begin
                            paddr_s  = ADDR_C;
                            pwdata_s = c_r;
                            state_s  = WR_C;
                        end
                        WR_C: begin
                            paddr_s  = ADDR_CTL;
                            pwdata_s = 32'h0;
                            state_s  = WR_CTL;
                        end
                        WR_CTL, POLL: begin
                            if (state_r == POLL) begin
                                poll_cnt_s = poll_inc_s;
                            end else begin
                                poll_cnt_s = poll_cnt_r;
                            end
                            if (state_r == POLL && !apb_prdata[0]) begin
                                paddr_s  = ADDR_RES;
                                pwrite_s = 1'b0;
                                pwdata_s = 32'h0;
                                state_s  = RD_RES;
                            end else if (state_r == POLL && poll_inc_s >= LIMIT) begin
                                psel_s      = 1'b0;
                                out_valid_s = 1'b1;
                                out_err_s   = 1'b1;
                                out_data_s  = 32'h0;
                                state_s     = OUT;
                            end else if (POLL_GAP == 0) begin
                                paddr_s  = ADDR_CTL;
                                pwrite_s = 1'b0;
                                pwdata_s = 32'h0;
                                state_s  = POLL;
                            end else begin
                                psel_s    = 1'b0;
                                gap_cnt_s = 8'd0;
                                state_s   = GAP;
                            end
                        end
                        RD_RES: begin
                            psel_s      = 1'b0;
                            out_valid_s = 1'b1;
                            out_err_s   = 1'b0;
                            out_data_s  = apb_prdata;
                            state_s     = OUT;
                        end
                        default: begin
                            psel_s  = 1'b0;
                            state_s = IDLE;
                        end
                    endcase
                end else begin
                    penable_s = 1'b1;
                end
            end
            default: begin
                psel_s     = 1'b0;
                penable_s  = 1'b0;
                in_ready_s = 1'b1;
                state_s    = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset releases the bus immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= 5'h0;
            pwdata_r    <= 32'h0;
            a_r         <= 32'h0;
            b_r         <= 32'h0;
            c_r         <= 32'h0;
            gap_cnt_r   <= 8'd0;
            poll_cnt_r  <= 16'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_err_r   <= 1'b0;
            out_data_r  <= 32'h0;
        end else begin
            state_r     <= state_s;
            psel_r      <= psel_s;
            penable_r   <= penable_s;
            pwrite_r    <= pwrite_s;
            paddr_r     <= paddr_s;
            pwdata_r    <= pwdata_s;
            a_r         <= a_s;
            b_r         <= b_s;
            c_r         <= c_s;
            gap_cnt_r   <= gap_cnt_s;
            poll_cnt_r  <= poll_cnt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_err_r   <= out_err_s;
            out_data_r  <= out_data_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_err     = out_err_r;
    assign apb_paddr   = paddr_r;
    assign apb_psel    = psel_r;
    assign apb_penable = penable_r;
    assign apb_pwrite  = pwrite_r;
    assign apb_pwdata  = pwdata_r;
endmodule

// File: tb/tb_apb_fmac_seq.sv
// Self-checking bench for apb_fmac_seq: APB slave model with wait states and a
// programmable busy count, table vectors, random ops against a transfer-list model.
module tb_apb_fmac_seq;
    localparam int GAP   = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
    logic [31:0] in_a = 32'h0, in_b = 32'h0, in_c = 32'h0, out_data;
    logic [4:0]  apb_paddr;
    logic        apb_psel, apb_penable, apb_pwrite;
    logic [31:0] apb_pwdata, apb_prdata = 32'h0;
    logic        apb_pready = 1'b0;

    always #5 clk = ~clk;

    apb_fmac_seq #(.POLL_GAP(GAP), .POLL_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err),
        .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
        .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata),
        .apb_prdata(apb_prdata), .apb_pready(apb_pready)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic [31:0] a, b, c, res;
        int          busy, ws, hold;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    xfer_t       log_q[$];
    xfer_t       exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          sl_busy = 0, sl_ws = 0, poll_idx = 0, wait_cnt = 0;
    logic [31:0] sl_res = 32'h0;
    logic [4:0]  s_addr;
    logic        s_wr;
    logic [31:0] s_data;
    vec_t        tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // APB slave: wait states per access, busy STATUS for sl_busy polls, noise on pready when idle
    always @(negedge clk) begin
        if (rst) begin
            wait_cnt   = 0;
            apb_pready = 1'b0;
        end else if (apb_psel && !apb_penable) begin
            s_addr     = apb_paddr;
            s_wr       = apb_pwrite;
            s_data     = apb_pwdata;
            wait_cnt   = 0;
            apb_pready = 1'($urandom_range(0, 1));
        end else if (apb_psel && apb_penable) begin
            check("addr_stable", 32'(apb_paddr), 32'(s_addr));
            check("write_stable", 32'(apb_pwrite), 32'(s_wr));
            check("wdata_stable", apb_pwdata, s_data);
            if (wait_cnt < sl_ws) begin
                wait_cnt++;
                apb_pready = 1'b0;
            end else begin
                apb_pready = 1'b1;
                log_q.push_back('{apb_paddr, apb_pwrite, apb_pwdata});
                if (!apb_pwrite && apb_paddr == 5'h14) begin
                    apb_prdata = {31'h0, 1'(poll_idx < sl_busy)};
                    poll_idx++;
                end else if (!apb_pwrite && apb_paddr == 5'h0C) begin
                    apb_prdata = sl_res;
                end else begin
                    apb_prdata = $urandom;
                end
            end
        end else begin
            apb_pready = 1'($urandom_range(0, 1));
            apb_prdata = $urandom;
        end
    end

    // Reference: the bus transfers one operation must produce, and its result
    task automatic model(inout vec_t v);
        int npolls;
        v.exp_err  = (v.busy >= LIMIT);
        v.exp_data = v.exp_err ? 32'h0 : v.res;
        npolls     = v.exp_err ? LIMIT : v.busy + 1;
        exp_q.delete();
        exp_q.push_back('{5'h00, 1'b1, v.a});
        exp_q.push_back('{5'h04, 1'b1, v.b});
        exp_q.push_back('{5'h08, 1'b1, v.c});
        exp_q.push_back('{5'h14, 1'b1, 32'h0});
        for (int i = 0; i < npolls; i++) exp_q.push_back('{5'h14, 1'b0, 32'h0});
        if (!v.exp_err) exp_q.push_back('{5'h0C, 1'b0, 32'h0});
    endtask

    task automatic handshake(input vec_t v);
        int k;
        sl_busy  = v.busy;
        sl_ws    = v.ws;
        sl_res   = v.res;
        poll_idx = 0;
        log_q.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_a = v.a; in_b = v.b; in_c = v.c;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_before_op", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int   k;
        vec_t m;
        m = v;
        model(m);
        handshake(v);
        k = 0;
        while (!out_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("out_valid_seen", 32'(out_valid), 32'h1);
        check("out_data", out_data, v.exp_data);
        check("out_err", 32'(out_err), 32'(v.exp_err));
        check("in_ready_busy", 32'(in_ready), 32'h0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'h1);
            check("hold_data", out_data, v.exp_data);
            check("hold_in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("valid_after_accept", 32'(out_valid), 32'h0);
        check("in_ready_after_accept", 32'(in_ready), 32'h1);
        check("xfer_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            check("xfer_addr", 32'(log_q[i].addr), 32'(exp_q[i].addr));
            check("xfer_dir", 32'(log_q[i].wr), 32'(exp_q[i].wr));
            if (exp_q[i].wr) check("xfer_wdata", log_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   k;
        //             a             b             c             res           busy ws hold err   data
        tbl[0] = '{32'h401a3237, 32'h3eae76d1, 32'h3ee9c749, 32'h3fe10000, 3, 0, 0, 1'b0, 32'h3fe10000};
        tbl[1] = '{32'h00000001, 32'h00000002, 32'h00000003, 32'hdeadbeef, 1, 2, 0, 1'b0, 32'hdeadbeef};
        tbl[2] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h12345678, 65535, 0, 0, 1'b1, 32'h0};
        tbl[3] = '{32'haaaa5555, 32'h5555aaaa, 32'h0f0f0f0f, 32'hcafef00d, 0, 1, 10, 1'b0, 32'hcafef00d};
        tbl[4] = '{32'h7f800000, 32'hff800000, 32'h80000000, 32'h87654321, 4, 2, 2, 1'b1, 32'h0};
        tbl[5] = '{32'hffffffff, 32'h00000000, 32'h3f800000, 32'h00000000, 0, 3, 1, 1'b0, 32'h0};

        // Reset with in_valid held high: nothing captured
        in_valid = 1'b1;
        in_a = 32'h12345678;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_psel", 32'(apb_psel), 32'h0);
        check("rst_penable", 32'(apb_penable), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_psel", 32'(apb_psel), 32'h0);
        check("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Latency with zero wait states and one idle poll
        v = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40a00000, 0, 0, 0, 1'b0, 32'h40a00000};
        handshake(v);
        check("lat_no_setup_yet", 32'(apb_psel), 32'h0);
        @(posedge clk);
        #1;
        check("lat_first_setup", {30'h0, apb_psel, apb_penable}, 32'h2);
        check("lat_first_addr", 32'(apb_paddr), 32'h0);
        k = 1;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("lat_out_valid_edge", 32'(k), 32'(13 + GAP));
        check("lat_out_data", out_data, 32'h40a00000);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        for (int i = 0; i < 6; i++) run_op(tbl[i]);

        for (int i = 0; i < 20; i++) begin
            v.a    = $urandom;
            v.b    = $urandom;
            v.c    = $urandom;
            v.res  = $urandom;
            v.busy = $urandom_range(0, 5);
            v.ws   = $urandom_range(0, 2);
            v.hold = $urandom_range(0, 3);
            model(v);
            run_op(v);
        end

        // Reset during the B write access: bus released at once, operation dropped
        v = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 0, 3, 0, 1'b0, 32'h0};
        handshake(v);
        k = 0;
        while (!(apb_psel && apb_penable && apb_paddr == 5'h04) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wr_b_access_seen", 32'(apb_psel && apb_penable && apb_paddr == 5'h04), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_psel", 32'(apb_psel), 32'h0);
        check("midrst_penable", 32'(apb_penable), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_in_ready", 32'(in_ready), 32'h1);
            check("midrst_out_valid", 32'(out_valid), 32'h0);
            check("midrst_psel_idle", 32'(apb_psel), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
